spi_mem_slave: RTL

Parametrised successor to the fixed 10-bit SPI slave plus 256x8 RAM pair: one block that decodes SPI frames of width 2+DATA_W, owns the memory, and returns read data on MISO. Adds configurable data/address width and depth, optional pointer auto-increment for bursts under one SS_n assertion, clean abort on early SS_n release, and address-range error reporting. SPI bit clock is the system clock: MOSI is sampled and MISO updated on rising clk while SS_n is low.

---
 rtl/spi_mem_pkg.sv | 22 ++
 rtl/spi_mem_array.sv | 23 ++
 rtl/spi_mem_slave.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared types and frame helpers for the SPI memory slave
package spi_mem_pkg;

  typedef enum logic [1:0] {
    WADDR = 2'b00,
    WDATA = 2'b01,
    RADDR = 2'b10,
    RDATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RX   = 2'b01,
    EXEC = 2'b10,
    TX   = 2'b11
  } state_t;

  function automatic int frame_width(input int data_w);
    return 2 + data_w;
  endfunction

endpackage

// File: rtl/spi_mem_array.sv
// rtl/spi_mem_array.sv - word memory, synchronous write, combinational read, contents not reset
module spi_mem_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_mem_slave.sv
// rtl/spi_mem_slave.sv - SPI frame decoder owning a word memory; reads return on MISO
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_abort,
  output logic addr_err
);

  localparam int FW = frame_width(DATA_W);
  localparam int CW = $clog2(DATA_W + 3);
  localparam logic [DATA_W:0]   DEPTH_V  = (DATA_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CW-1:0]     RX_LAST  = CW'(FW - 1);
  localparam logic [CW-1:0]     TX_INIT  = CW'(DATA_W - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FW-1:0]     rx_sr, rx_n;
  logic [DATA_W-1:0] tx_sr, tx_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic              miso_n, abort_n, err_n, we;
  logic [DATA_W-1:0] rdata, payload;
  logic              addr_ok;
  cmd_t              cmd;

  assign cmd     = cmd_t'(rx_sr[FW-1 -: 2]);
  assign payload = rx_sr[DATA_W-1:0];
  assign addr_ok = {1'b0, payload} < DEPTH_V;
  assign busy    = (state != IDLE);

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  spi_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (payload),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rx_n     = rx_sr;
    tx_n     = tx_sr;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    miso_n   = MISO;
    abort_n  = 1'b0;
    err_n    = 1'b0;
    we       = 1'b0;
    // Deselect mid-frame discards everything, including a command sitting in EXEC.
    if (state != IDLE && SS_n) begin
      state_n = IDLE;
      cnt_n   = '0;
      rx_n    = '0;
      tx_n    = '0;
      miso_n  = 1'b0;
      abort_n = 1'b1;
    end else begin
      case (state)
        IDLE: if (!SS_n) begin
          rx_n    = {{(FW-1){1'b0}}, MOSI};
          cnt_n   = CW'(1);
          state_n = RX;
        end
        RX: begin
          rx_n  = {rx_sr[FW-2:0], MOSI};
          cnt_n = cnt + 1'b1;
          if (cnt == RX_LAST) state_n = EXEC;
        end
        EXEC: begin
          state_n = IDLE;
          cnt_n   = '0;
          case (cmd)
            WADDR: if (addr_ok) wr_ptr_n = payload[ADDR_W-1:0]; else err_n = 1'b1;
            RADDR: if (addr_ok) rd_ptr_n = payload[ADDR_W-1:0]; else err_n = 1'b1;
            WDATA: begin
              we = 1'b1;
              if (AUTO_INC != 0) wr_ptr_n = next_ptr(wr_ptr);
            end
            RDATA: begin
              miso_n  = rdata[DATA_W-1];
              tx_n    = rdata << 1;
              cnt_n   = TX_INIT;
              state_n = TX;
              if (AUTO_INC != 0) rd_ptr_n = next_ptr(rd_ptr);
            end
          endcase
        end
        TX: if (cnt != '0) begin
          miso_n = tx_sr[DATA_W-1];
          tx_n   = tx_sr << 1;
          cnt_n  = cnt - 1'b1;
        end else begin
          miso_n  = 1'b0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      MISO        <= 1'b0;
      frame_abort <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rx_sr       <= rx_n;
      tx_sr       <= tx_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      MISO        <= miso_n;
      frame_abort <= abort_n;
      addr_err    <= err_n;
    end
  end

endmodule
